muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller beside the main ALU in the MIPS datapath.
- Sequences an iterative 32-step shift-add multiplier and restoring divider over shared magnitude/accumulator registers.
- Owns the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- The pipeline stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- STEPS, WIDTH, number of iteration cycles in the CALC state; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe, sampled only in IDLE
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops
- a  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data
- b  input  WIDTH  rt operand: multiplier or divisor
- busy  output  1  high while an arithmetic op is in flight
- done  output  1  one-cycle pulse when HI/LO take a new arithmetic result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `reset`.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, internal registers cleared.
- Reset mid-operation aborts the op. No done pulse is produced and HI/LO read 0 in the cycle after the reset edge.
- States: IDLE, CALC, SIGN.
- IDLE with start=1 and op in {000..011} (edge k):
  - latch |a| and |b| (absolute value only for signed ops; |0x80000000| = 0x80000000 as unsigned);
  - latch result-sign flags: quotient/product sign = a[31]^b[31]; remainder sign = a[31];
  - clear the step counter; go to CALC.
- IDLE with start=1 and op=100: hi<=a at edge k. op=101: lo<=a at edge k. No busy, no done.
- IDLE with start=1 and op 110/111: ignored.
- CALC: one iteration per cycle for STEPS cycles, then go to SIGN.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder.
- SIGN (one cycle):
  - Signed multiply: apply two's-complement negation to the 64-bit product when its sign flag is set.
  - Signed divide: negate quotient and remainder per their flags. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Write hi/lo at the SIGN exit edge (k+STEPS+2) and return to IDLE.
- Latency and handshake:
  - busy=1 for exactly STEPS+2 = 34 cycles, i.e. edges k .. k+34.
  - done=1 for exactly one cycle, after edge k+34, coincident with busy falling and new hi/lo visible.
  - start and op are ignored entirely while busy=1, including MTHI/MTLO.
  - a and b need be valid only at edge k; they are not re-sampled.
- Divide by zero (b=0), signed or unsigned:
  - same 34-cycle latency;
  - lo=all-ones, hi=a (raw dividend, no sign fixup).
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (two's-complement wrap, no trap).
- HI/LO hold their values between writes. Any arithmetic op writes both.
- MTHI writes only hi; MTLO writes only lo.
- done=0 whenever not in the single result cycle.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done pulses exactly 34 cycles after the start edge; busy high for those 34 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Then MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5 after 34 cycles. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 in IDLE -> hi=0x12345678 next cycle; lo unchanged; busy and done stay 0. Start MULTU 3*4, then pulse start op=101 and op=000 mid-CALC -> both ignored; final hi=0, lo=12.
- Start DIVU 1000/3, assert reset at cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse ever. A subsequent DIVU 9/2 completes normally with lo=4, hi=1.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer owning the architectural HI/LO registers.
// Signed ops run on magnitudes; the sign is restored in a single fix-up cycle.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LastCnt = CW'(STEPS);

    typedef enum logic [1:0] {StIdle, StCalc, StSign} state_e;

    state_e             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;

    logic               is_signed_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rmd;

    always_comb begin
        is_signed_op = ~op[0];
        abs_a = (is_signed_op && a[WIDTH-1]) ? -a : a;
        abs_b = (is_signed_op && b[WIDTH-1]) ? -b : b;
    end

    // acc holds {upper product, multiplier} for multiply, {remainder, quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd};
        if (is_div) begin
            if (!div_trial[WIDTH]) begin
                acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rmd  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= StIdle;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        if (!op[2]) begin
                            acc    <= {{WIDTH{1'b0}}, abs_a};
                            opnd   <= abs_b;
                            is_div <= op[1];
                            // Divide by zero keeps the all-ones quotient unsigned; the
                            // remainder negation then hands back the raw dividend.
                            neg_q  <= is_signed_op && (a[WIDTH-1] ^ b[WIDTH-1]) &&
                                      !(op[1] && (b == '0));
                            neg_r  <= is_signed_op && a[WIDTH-1];
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= StCalc;
                        end else if (op[1:0] == 2'b00) begin
                            hi <= a;
                        end else if (op[1:0] == 2'b01) begin
                            lo <= a;
                        end
                    end
                end
                StCalc: begin
                    if (cnt == LastCnt) begin
                        state <= StSign;
                    end else begin
                        acc <= acc_step;
                        cnt <= cnt + 1'b1;
                    end
                end
                StSign: begin
                    if (is_div) begin
                        hi <= rmd;
                        lo <= quo;
                    end else begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
